// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator and its read-side divider.
//   ACC_W       accumulator / dividend / quotient width
//   OP_W        MAC operand / divisor / remainder width
//   DIV_Q_ONES  quotient reported for a divide by zero
//   div_state_t divider control states
package mac_pkg;

    localparam int ACC_W = 16;
    localparam int OP_W  = 8;

    localparam logic [ACC_W-1:0] DIV_Q_ONES = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/mac_acc_divider_div_step.sv
// One restoring-division iteration (purely combinational).
//   pr_i      partial remainder from the previous step (VW+1 bits)
//   bit_i     next dividend bit, MSB first
//   divisor_i divisor
//   pr_o      updated partial remainder
//   q_o       quotient bit produced by this step
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   pr_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   pr_o,
    output logic          q_o
);

    logic [VW:0] shifted;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and dropping it in the shift loses nothing.
    assign shifted = {pr_i[VW-1:0], bit_i};

    always_comb begin
        if (shifted >= {1'b0, divisor_i}) begin
            pr_o = shifted - {1'b0, divisor_i};
            q_o  = 1'b1;
        end else begin
            pr_o = shifted;
            q_o  = 1'b0;
        end
    end

endmodule

// File: rtl/mac_acc_divider.sv
// Sequential restoring divider on the read side of the MAC accumulator.
// One quotient bit per clock, valid/ready on both sides.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (dividend DW, divisor VW)
//   out_valid/out_ready      result handshake
//   quotient, remainder      unsigned result
//   div_by_zero              result came from a zero divisor
module mac_acc_divider
    import mac_pkg::*;
#(
    parameter int DW = ACC_W,
    parameter int VW = OP_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;   // dividend shifts out the top, quotient shifts in the bottom
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   pr_q, pr_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ov_q, ov_d;

    logic [VW:0]   step_pr;
    logic          step_qbit;

    div_step #(.VW(VW)) u_step (
        .pr_i      (pr_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .pr_o      (step_pr),
        .q_o       (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    pr_d    = '0;
                    cnt_d   = CW'(DW - 1);
                    state_d = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                dvd_d = {dvd_q[DW-2:0], step_qbit};
                pr_d  = step_pr;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = {dvd_q[DW-2:0], step_qbit};
                    rem_d   = step_pr[VW-1:0];
                    dbz_d   = 1'b0;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Only the divide-by-zero path arrives here without a loaded
                // result; it spends its one cycle loading the fixed answer.
                if (!ov_q) begin
                    quo_d = {DW{1'b1}};
                    rem_d = '0;
                    dbz_d = 1'b1;
                    ov_d  = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = ov_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mac_acc_divider.sv
module tb_mac_acc_divider;
    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    always #5 clk = ~clk;

    mac_acc_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Offer a pair, wait (bounded) for in_ready, return just after the accept edge.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input bit push, output bit ok);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = 16'hFFFF; e.r = '0; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / DW'(b); e.r = VW'(a % DW'(b)); e.dbz = 1'b0; e.lat = DW;
        end
        if (ok && push) sb.push_back(e);
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== '0 || div_by_zero !== 1'b0) begin errors++;
            $display("FAIL reset_r_dbz got=%0d/%b exp=0/0", remainder, div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    // Directed pairs: main case, boundaries, divide by zero.
    task automatic test_directed();
        logic [DW-1:0] ta [5] = '{16'd1000, 16'd65535, 16'd3, 16'd5, 16'd777};
        logic [VW-1:0] tb [5] = '{8'd7, 8'd255, 8'd200, 8'd0, 8'd1};
        for (int i = 0; i < 5; i++) begin
            bit   ok;
            int   cyc;
            exp_t e;
            issue(ta[i], tb[i], 1'b1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL dir_accept[%0d] got=0 exp=1", i); continue; end
            wait_out(cyc);
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || cyc != e.lat) begin errors++;
                $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, cyc, e.lat); end
            checks++; if (quotient !== e.q) begin errors++;
                $display("FAIL dir_q[%0d] got=%0d exp=%0d", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin errors++;
                $display("FAIL dir_r[%0d] got=%0d exp=%0d", i, remainder, e.r); end
            checks++; if (div_by_zero !== e.dbz) begin errors++;
                $display("FAIL dir_dbz[%0d] got=%b exp=%b", i, div_by_zero, e.dbz); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
                $display("FAIL dir_release[%0d] got=%b/%b exp=0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   cyc;
        exp_t e;
        @(negedge clk);
        out_ready = 1'b0;
        issue(16'd1000, 8'd7, 1'b1, ok);
        wait_out(cyc);
        checks++; if (!ok || out_valid !== 1'b1 || sb.size() == 0) begin errors++;
            $display("FAIL bp_first got=%b exp=1", out_valid); end
        if (sb.size() != 0) void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = 16'd100; divisor = 8'd9;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_hold[%0d] got=%b/%b exp=1/0", i, out_valid, in_ready); end
            checks++; if (quotient !== 16'd142 || remainder !== 8'd6) begin errors++;
                $display("FAIL bp_stable[%0d] got=%0d/%0d exp=142/6", i, quotient, remainder); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_idle got=%b/%b exp=0/1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept2 got=%b exp=0", in_ready); end
        e.a = 16'd100; e.b = 8'd9; e.q = 16'd11; e.r = 8'd1; e.dbz = 1'b0; e.lat = DW;
        sb.push_back(e);
        wait_out(cyc);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || cyc != e.lat) begin errors++;
            $display("FAIL bp_lat2 got=%0d exp=%0d", cyc, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin errors++;
            $display("FAIL bp_result2 got=%0d/%0d exp=%0d/%0d", quotient, remainder, e.q, e.r); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   cyc;
        exp_t e;
        issue(16'd1000, 8'd7, 1'b0, ok);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL midrst_state got=%b/%b exp=1/0", in_ready, out_valid); end
        checks++; if (quotient !== '0 || remainder !== '0) begin errors++;
            $display("FAIL midrst_clear got=%0d/%0d exp=0/0", quotient, remainder); end
        @(negedge clk);
        rst = 1'b0;
        issue(16'd100, 8'd10, 1'b1, ok);
        wait_out(cyc);
        checks++; if (!ok || sb.size() == 0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL midrst_next got=%b exp=1", out_valid); end
        else begin
            e = sb.pop_front();
            checks++; if (quotient !== e.q || remainder !== e.r || cyc != e.lat) begin errors++;
                $display("FAIL midrst_result got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         quotient, remainder, cyc, e.q, e.r, e.lat); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 1000; n++) begin
            logic [DW-1:0] a;
            logic [VW-1:0] b;
            bit            ok;
            int            cyc;
            exp_t          e;
            a = DW'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'd0;
                1: b = 8'd1;
                2: b = 8'd255;
                default: b = VW'($urandom);
            endcase
            if (n % 97 == 0) a = 16'hFFFF;
            issue(a, b, 1'b1, ok);
            wait_out(cyc);
            if (!ok || sb.size() == 0 || out_valid !== 1'b1) begin
                checks++; errors++;
                $display("FAIL b2b_timeout[%0d] got=%b exp=1", n, out_valid);
                if (sb.size() != 0) void'(sb.pop_front());
                continue;
            end
            e = sb.pop_front();
            checks++; if (cyc != e.lat) begin errors++;
                $display("FAIL b2b_lat[%0d] got=%0d exp=%0d", n, cyc, e.lat); end
            checks++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin errors++;
                $display("FAIL b2b_result[%0d] %0d/%0d got=%0d r%0d z%b exp=%0d r%0d z%b", n, e.a, e.b,
                         quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
            if (e.b != 0) begin
                checks++;
                if (longint'(quotient) * longint'(e.b) + longint'(remainder) != longint'(e.a) ||
                    remainder >= e.b) begin
                    errors++;
                    $display("FAIL b2b_identity[%0d] got=%0d*%0d+%0d exp=%0d", n, quotient, e.b, remainder, e.a);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
